// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared decode constants and the ID/EX control word.
// Holds the 5-bit opcode values, the writeback-select encodings, and the
// packed control word that ctrl_decode produces and hazard_ctrl_unit registers.
package ctrl_pkg;

  localparam logic [4:0] OP_R     = 5'b01100;
  localparam logic [4:0] OP_I     = 5'b00100;
  localparam logic [4:0] OP_LD    = 5'b00000;
  localparam logic [4:0] OP_ST    = 5'b01000;
  localparam logic [4:0] OP_BR    = 5'b11000;
  localparam logic [4:0] OP_JAL   = 5'b11011;
  localparam logic [4:0] OP_JALR  = 5'b11001;
  localparam logic [4:0] OP_LUI   = 5'b01101;
  localparam logic [4:0] OP_AUIPC = 5'b00101;

  localparam logic [1:0] WB_LD  = 2'd0;  // load data
  localparam logic [1:0] WB_ALU = 2'd1;  // ALU result
  localparam logic [1:0] WB_PC4 = 2'd2;  // PC+4

  typedef struct packed {
    logic       rd_wren;
    logic       mem_wren;
    logic       op_a_sel;
    logic       op_b_sel;
    logic       br_unsigned;
    logic       jmp_sel;
    logic       is_branch;
    logic [1:0] wb_sel;
  } ctrl_word_t;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational decode of the ID-stage instruction.
// Ports:
//   instr_i     in  WIDTH  instruction in ID
//   ctrl_o      out        decoded control word (all zero for undefined opcodes)
//   rs1_used_o  out  1     instruction reads rs1
//   rs2_used_o  out  1     instruction reads rs2
//   rd_o, rs1_o, rs2_o out 5 register address fields
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] instr_i,
  output ctrl_word_t       ctrl_o,
  output logic             rs1_used_o,
  output logic             rs2_used_o,
  output logic [4:0]       rd_o,
  output logic [4:0]       rs1_o,
  output logic [4:0]       rs2_o
);

  assign rd_o  = instr_i[11:7];
  assign rs1_o = instr_i[19:15];
  assign rs2_o = instr_i[24:20];

  // Fields not needed for control or interlock decisions.
  logic unused_bits;
  assign unused_bits = &{1'b0, instr_i[WIDTH-1:25], instr_i[14], instr_i[12], instr_i[1:0]};

  always_comb begin
    ctrl_o     = '0;
    rs1_used_o = 1'b0;
    rs2_used_o = 1'b0;
    unique case (instr_i[6:2])
      OP_R: begin
        ctrl_o.rd_wren = 1'b1;
        ctrl_o.wb_sel  = WB_ALU;
        rs1_used_o     = 1'b1;
        rs2_used_o     = 1'b1;
      end
      OP_I: begin
        ctrl_o.rd_wren  = 1'b1;
        ctrl_o.op_b_sel = 1'b1;
        ctrl_o.wb_sel   = WB_ALU;
        rs1_used_o      = 1'b1;
      end
      OP_LD: begin
        ctrl_o.rd_wren  = 1'b1;
        ctrl_o.op_b_sel = 1'b1;
        ctrl_o.wb_sel   = WB_LD;
        rs1_used_o      = 1'b1;
      end
      OP_ST: begin
        ctrl_o.mem_wren = 1'b1;
        ctrl_o.op_b_sel = 1'b1;
        ctrl_o.wb_sel   = WB_PC4;
        rs1_used_o      = 1'b1;
        rs2_used_o      = 1'b1;
      end
      OP_BR: begin
        ctrl_o.is_branch   = 1'b1;
        ctrl_o.op_a_sel    = 1'b1;
        ctrl_o.op_b_sel    = 1'b1;
        ctrl_o.wb_sel      = WB_PC4;
        ctrl_o.br_unsigned = instr_i[13];  // funct3[1] selects BLTU/BGEU
        rs1_used_o         = 1'b1;
        rs2_used_o         = 1'b1;
      end
      OP_JAL: begin
        ctrl_o.rd_wren  = 1'b1;
        ctrl_o.op_a_sel = 1'b1;
        ctrl_o.op_b_sel = 1'b1;
        ctrl_o.wb_sel   = WB_PC4;
        ctrl_o.jmp_sel  = 1'b1;
      end
      OP_JALR: begin
        ctrl_o.rd_wren  = 1'b1;
        ctrl_o.op_b_sel = 1'b1;
        ctrl_o.wb_sel   = WB_PC4;
        ctrl_o.jmp_sel  = 1'b1;
        rs1_used_o      = 1'b1;
      end
      OP_LUI: begin
        ctrl_o.rd_wren  = 1'b1;
        ctrl_o.op_b_sel = 1'b1;
        ctrl_o.wb_sel   = WB_ALU;
      end
      OP_AUIPC: begin
        ctrl_o.rd_wren  = 1'b1;
        ctrl_o.op_a_sel = 1'b1;
        ctrl_o.op_b_sel = 1'b1;
        ctrl_o.wb_sel   = WB_ALU;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: ID-stage decode, RAW interlock and ID/EX control register.
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   instruction, id_valid   instruction in ID and its valid flag
//   br_taken                EX instruction redirects the PC
//   stall, flush_if_id      combinational pipeline control
//   ex_*                    registered control word at the ID/EX boundary
//   stall_cnt               saturating count of stall cycles
module hazard_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int HAZ_DEPTH = 3,
  parameter int CNT_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] instruction,
  input  logic             id_valid,
  input  logic             br_taken,
  output logic             stall,
  output logic             flush_if_id,
  output logic             ex_valid,
  output logic             ex_rd_wren,
  output logic             ex_mem_wren,
  output logic             ex_op_a_sel,
  output logic             ex_op_b_sel,
  output logic             ex_br_unsigned,
  output logic             ex_jmp_sel,
  output logic             ex_is_branch,
  output logic [1:0]       ex_wb_sel,
  output logic [4:0]       ex_rd_addr,
  output logic [CNT_W-1:0] stall_cnt
);

  ctrl_word_t dec_ctrl;
  logic       rs1_used, rs2_used;
  logic [4:0] rd, rs1, rs2;

  ctrl_decode #(.WIDTH(WIDTH)) u_decode (
    .instr_i    (instruction),
    .ctrl_o     (dec_ctrl),
    .rs1_used_o (rs1_used),
    .rs2_used_o (rs2_used),
    .rd_o       (rd),
    .rs1_o      (rs1),
    .rs2_o      (rs2)
  );

  // Scoreboard: entry 0 is the instruction now in EX, the last entry is the
  // oldest write not yet visible to a register-file read in ID.
  logic [HAZ_DEPTH-1:0]      sb_vld_q, sb_vld_d;
  logic [HAZ_DEPTH-1:0][4:0] sb_rd_q,  sb_rd_d;

  ctrl_word_t        ex_ctrl_q, ex_ctrl_d;
  logic              ex_valid_q, ex_valid_d;
  logic [4:0]        ex_rd_q, ex_rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic rs1_hit, rs2_hit, hazard, issue;

  always_comb begin
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    for (int k = 0; k < HAZ_DEPTH; k++) begin
      if (sb_vld_q[k] && (sb_rd_q[k] == rs1)) rs1_hit = 1'b1;
      if (sb_vld_q[k] && (sb_rd_q[k] == rs2)) rs2_hit = 1'b1;
    end
  end

  // x0 never creates a dependency even if an entry somehow held it.
  assign hazard = id_valid & ((rs1_used & rs1_hit & (rs1 != 5'd0)) |
                              (rs2_used & rs2_hit & (rs2 != 5'd0)));
  // A redirect discards ID, so it masks the stall rather than holding ID.
  assign stall       = hazard & ~br_taken;
  assign flush_if_id = br_taken;
  assign issue       = id_valid & ~hazard & ~br_taken;

  always_comb begin
    sb_vld_d    = '0;
    sb_rd_d     = '0;
    sb_vld_d[0] = issue & dec_ctrl.rd_wren & (rd != 5'd0);
    sb_rd_d[0]  = sb_vld_d[0] ? rd : 5'd0;
    for (int k = 1; k < HAZ_DEPTH; k++) begin
      sb_vld_d[k] = sb_vld_q[k-1];
      sb_rd_d[k]  = sb_rd_q[k-1];
    end
  end

  always_comb begin
    ex_ctrl_d  = '0;
    ex_valid_d = 1'b0;
    ex_rd_d    = 5'd0;
    if (issue) begin
      ex_ctrl_d  = dec_ctrl;
      ex_valid_d = 1'b1;
      ex_rd_d    = rd;
    end
  end

  assign cnt_d = (stall && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sb_vld_q   <= '0;
      sb_rd_q    <= '0;
      ex_ctrl_q  <= '0;
      ex_valid_q <= 1'b0;
      ex_rd_q    <= 5'd0;
      cnt_q      <= '0;
    end else begin
      sb_vld_q   <= sb_vld_d;
      sb_rd_q    <= sb_rd_d;
      ex_ctrl_q  <= ex_ctrl_d;
      ex_valid_q <= ex_valid_d;
      ex_rd_q    <= ex_rd_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ex_valid       = ex_valid_q;
  assign ex_rd_wren     = ex_ctrl_q.rd_wren;
  assign ex_mem_wren    = ex_ctrl_q.mem_wren;
  assign ex_op_a_sel    = ex_ctrl_q.op_a_sel;
  assign ex_op_b_sel    = ex_ctrl_q.op_b_sel;
  assign ex_br_unsigned = ex_ctrl_q.br_unsigned;
  assign ex_jmp_sel     = ex_ctrl_q.jmp_sel;
  assign ex_is_branch   = ex_ctrl_q.is_branch;
  assign ex_wb_sel      = ex_ctrl_q.wb_sel;
  assign ex_rd_addr     = ex_rd_q;
  assign stall_cnt      = cnt_q;

endmodule
